aha_tlx_axi_master: RTL

AXI4 initiator that drives the TLX port from a simple command/stream interface, the master-side counterpart of the TLX slave integration. It accepts one burst command at a time, issues AW+W+B or AR+R on the 64-bit TLX channels, and reports completion with a status pulse. It sits between an SoC-side DMA or test engine and the TLX slave port.

---
 rtl/aha_tlx_axi_master.sv | 308 ++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/aha_tlx_axi_master.sv
`default_nettype none
// ============================================================================
// Module   : aha_tlx_axi_master
// Purpose  : Single-outstanding AXI4 initiator for the 64-bit TLX port.
//            Accepts one burst command at a time from a simple command and
//            stream interface, runs AW+W+B or AR+R, and reports completion
//            with a one-cycle DONE pulse carrying an AXI response code.
// Options  : AHA_TLX_MASTER_4K_CHECK_EN - when defined, commands whose burst
//            would cross a 4 KB boundary are completed immediately with
//            SLVERR and generate no AXI traffic.
// Revision : 1.0 - initial release
// ============================================================================
module aha_tlx_axi_master #(
    parameter logic [3:0] CACHE_ATTR = 4'b0011,
    parameter logic [2:0] PROT_ATTR  = 3'b000
) (
    input  logic        TLX_CLK,
    input  logic        TLX_RESETn,

    // Command interface
    input  logic        CMD_VALID,
    output logic        CMD_READY,
    input  logic        CMD_WRITE,
    input  logic [3:0]  CMD_ID,
    input  logic [31:0] CMD_ADDR,
    input  logic [7:0]  CMD_LEN,

    // Write beat stream
    input  logic [63:0] WR_DATA,
    input  logic [7:0]  WR_STRB,
    input  logic        WR_VALID,
    output logic        WR_READY,

    // Read beat stream
    output logic [63:0] RD_DATA,
    output logic        RD_LAST,
    output logic        RD_VALID,
    input  logic        RD_READY,

    // Completion
    output logic        DONE,
    output logic [1:0]  DONE_RESP,

    // AXI write address channel
    output logic [3:0]  TLX_AWID,
    output logic [31:0] TLX_AWADDR,
    output logic [7:0]  TLX_AWLEN,
    output logic [2:0]  TLX_AWSIZE,
    output logic [1:0]  TLX_AWBURST,
    output logic        TLX_AWLOCK,
    output logic [3:0]  TLX_AWCACHE,
    output logic [2:0]  TLX_AWPROT,
    output logic        TLX_AWVALID,
    input  logic        TLX_AWREADY,

    // AXI write data channel
    output logic [63:0] TLX_WDATA,
    output logic [7:0]  TLX_WSTRB,
    output logic        TLX_WLAST,
    output logic        TLX_WVALID,
    input  logic        TLX_WREADY,

    // AXI write response channel
    input  logic [3:0]  TLX_BID,
    input  logic [1:0]  TLX_BRESP,
    input  logic        TLX_BVALID,
    output logic        TLX_BREADY,

    // AXI read address channel
    output logic [3:0]  TLX_ARID,
    output logic [31:0] TLX_ARADDR,
    output logic [7:0]  TLX_ARLEN,
    output logic [2:0]  TLX_ARSIZE,
    output logic [1:0]  TLX_ARBURST,
    output logic        TLX_ARLOCK,
    output logic [3:0]  TLX_ARCACHE,
    output logic [2:0]  TLX_ARPROT,
    output logic        TLX_ARVALID,
    input  logic        TLX_ARREADY,

    // AXI read data channel
    input  logic [3:0]  TLX_RID,
    input  logic [63:0] TLX_RDATA,
    input  logic [1:0]  TLX_RRESP,
    input  logic        TLX_RLAST,
    input  logic        TLX_RVALID,
    output logic        TLX_RREADY
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_AW   = 3'd1;
    localparam logic [2:0] S_W    = 3'd2;
    localparam logic [2:0] S_B    = 3'd3;
    localparam logic [2:0] S_AR   = 3'd4;
    localparam logic [2:0] S_R    = 3'd5;

    localparam logic [1:0] c_RESP_OKAY   = 2'b00;
    localparam logic [1:0] c_RESP_SLVERR = 2'b10;
    localparam logic [2:0] c_SIZE_8B     = 3'b011;
    localparam logic [1:0] c_BURST_INCR  = 2'b01;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [2:0]  state_q,     state_d;
    logic [3:0]  id_q,        id_d;
    logic [31:0] addr_q,      addr_d;
    logic [7:0]  len_q,       len_d;
    logic [7:0]  cnt_q,       cnt_d;
    logic [1:0]  resp_q,      resp_d;
    logic        done_q,      done_d;
    logic [1:0]  done_resp_q, done_resp_d;

    logic        w_cnt_at_len;
    logic        w_in_aw;
    logic        w_in_ar;
    logic        w_in_w;
    logic        w_in_r;
    logic [1:0]  w_beat_resp;

    // Address LSBs are forced to zero; they are intentionally not consumed.
    logic        w_unused_addr_lsb;
    assign w_unused_addr_lsb = ^CMD_ADDR[2:0];

`ifdef AHA_TLX_MASTER_4K_CHECK_EN
    // End address of the burst relative to its 4 KB page; anything past 4096
    // means the burst would spill into the next page.
    logic [12:0] w_4k_end;
    logic        w_4k_cross;
    assign w_4k_end   = {1'b0, CMD_ADDR[11:3], 3'b000}
                      + {1'b0, ({1'b0, CMD_LEN} + 9'd1), 3'b000};
    assign w_4k_cross = (w_4k_end > 13'd4096);
`endif

    assign w_cnt_at_len = (cnt_q == len_q);
    assign w_in_aw      = (state_q == S_AW);
    assign w_in_ar      = (state_q == S_AR);
    assign w_in_w       = (state_q == S_W);
    assign w_in_r       = (state_q == S_R);

    // ------------------------------------------------------------------------
    // Output decode: channel signals are qualified by state so every valid
    // drops as soon as the state register is cleared by reset.
    // ------------------------------------------------------------------------
    assign CMD_READY   = (state_q == S_IDLE);

    assign TLX_AWVALID = w_in_aw;
    assign TLX_AWID    = w_in_aw ? id_q         : 4'd0;
    assign TLX_AWADDR  = w_in_aw ? addr_q       : 32'd0;
    assign TLX_AWLEN   = w_in_aw ? len_q        : 8'd0;
    assign TLX_AWSIZE  = w_in_aw ? c_SIZE_8B    : 3'd0;
    assign TLX_AWBURST = w_in_aw ? c_BURST_INCR : 2'd0;
    assign TLX_AWLOCK  = 1'b0;
    assign TLX_AWCACHE = w_in_aw ? CACHE_ATTR   : 4'd0;
    assign TLX_AWPROT  = w_in_aw ? PROT_ATTR    : 3'd0;

    assign TLX_ARVALID = w_in_ar;
    assign TLX_ARID    = w_in_ar ? id_q         : 4'd0;
    assign TLX_ARADDR  = w_in_ar ? addr_q       : 32'd0;
    assign TLX_ARLEN   = w_in_ar ? len_q        : 8'd0;
    assign TLX_ARSIZE  = w_in_ar ? c_SIZE_8B    : 3'd0;
    assign TLX_ARBURST = w_in_ar ? c_BURST_INCR : 2'd0;
    assign TLX_ARLOCK  = 1'b0;
    assign TLX_ARCACHE = w_in_ar ? CACHE_ATTR   : 4'd0;
    assign TLX_ARPROT  = w_in_ar ? PROT_ATTR    : 3'd0;

    assign TLX_WVALID  = w_in_w & WR_VALID;
    assign WR_READY    = w_in_w & TLX_WREADY;
    assign TLX_WDATA   = WR_DATA;
    assign TLX_WSTRB   = WR_STRB;
    assign TLX_WLAST   = w_in_w & w_cnt_at_len;

    assign TLX_BREADY  = (state_q == S_B);

    assign RD_VALID    = w_in_r & TLX_RVALID;
    assign TLX_RREADY  = w_in_r & RD_READY;
    assign RD_DATA     = TLX_RDATA;
    assign RD_LAST     = TLX_RLAST;

    assign DONE        = done_q;
    assign DONE_RESP   = done_resp_q;

    // Response for the current read beat: keep the first non-OKAY code, but
    // protocol violations (wrong ID, missing or early RLAST) force SLVERR.
    always_comb begin
        w_beat_resp = resp_q;
        if ((resp_q == c_RESP_OKAY) && (TLX_RRESP != c_RESP_OKAY)) begin
            w_beat_resp = TLX_RRESP;
        end
        if (TLX_RID != id_q) begin
            w_beat_resp = c_RESP_SLVERR;
        end
        if (TLX_RLAST != w_cnt_at_len) begin
            w_beat_resp = c_RESP_SLVERR;
        end
    end

    // Next-state logic for the burst sequencer.
    always_comb begin
        state_d     = state_q;
        id_d        = id_q;
        addr_d      = addr_q;
        len_d       = len_q;
        cnt_d       = cnt_q;
        resp_d      = resp_q;
        done_d      = 1'b0;
        done_resp_d = done_resp_q;

        case (state_q)
            S_IDLE: begin
                if (CMD_VALID) begin
                    id_d   = CMD_ID;
                    addr_d = {CMD_ADDR[31:3], 3'b000};
                    len_d  = CMD_LEN;
                    cnt_d  = 8'd0;
                    resp_d = c_RESP_OKAY;
`ifdef AHA_TLX_MASTER_4K_CHECK_EN
                    if (w_4k_cross) begin
                        done_d      = 1'b1;
                        done_resp_d = c_RESP_SLVERR;
                    end else begin
                        state_d = CMD_WRITE ? S_AW : S_AR;
                    end
`else
                    state_d = CMD_WRITE ? S_AW : S_AR;
`endif
                end
            end

            S_AW: begin
                if (TLX_AWREADY) begin
                    state_d = S_W;
                end
            end

            S_W: begin
                if (WR_VALID && TLX_WREADY) begin
                    if (w_cnt_at_len) begin
                        state_d = S_B;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
            end

            S_B: begin
                if (TLX_BVALID) begin
                    done_d      = 1'b1;
                    done_resp_d = (TLX_BID != id_q) ? c_RESP_SLVERR : TLX_BRESP;
                    state_d     = S_IDLE;
                end
            end

            S_AR: begin
                if (TLX_ARREADY) begin
                    state_d = S_R;
                end
            end

            S_R: begin
                if (TLX_RVALID && RD_READY) begin
                    resp_d = w_beat_resp;
                    // Counter saturates at LEN; extra beats keep it there.
                    if (!w_cnt_at_len) begin
                        cnt_d = cnt_q + 8'd1;
                    end
                    if (TLX_RLAST) begin
                        done_d      = 1'b1;
                        done_resp_d = w_beat_resp;
                        state_d     = S_IDLE;
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and burst context registers, cleared asynchronously.
    always_ff @(posedge TLX_CLK or negedge TLX_RESETn) begin
        if (!TLX_RESETn) begin
            state_q     <= S_IDLE;
            id_q        <= 4'd0;
            addr_q      <= 32'd0;
            len_q       <= 8'd0;
            cnt_q       <= 8'd0;
            resp_q      <= c_RESP_OKAY;
            done_q      <= 1'b0;
            done_resp_q <= c_RESP_OKAY;
        end else begin
            state_q     <= state_d;
            id_q        <= id_d;
            addr_q      <= addr_d;
            len_q       <= len_d;
            cnt_q       <= cnt_d;
            resp_q      <= resp_d;
            done_q      <= done_d;
            done_resp_q <= done_resp_d;
        end
    end

endmodule
`default_nettype wire
